// File: rtl/ram_ctrl.sv
// Single-port RAM access controller: serves one read or write per request,
// or fills every address with one value, acknowledging each with a single-cycle pulse.
module ram_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              fill_i,
    output logic              ack_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic [1:0]        dbg_state_o
);

    // Handshake: req_i/fill_i are only sampled in IDLE (fill wins); the
    // requester must hold inputs stable at that edge, and completion is
    // signalled by ack_o high for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FILL   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                we_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                lat_load;
    logic                fill_start;

    always_comb begin
        state_d    = state_q;
        lat_load   = 1'b0;
        fill_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_i) begin
                    state_d    = FILL;
                    fill_start = 1'b1;
                end else if (req_i) begin
                    state_d  = ACCESS;
                    lat_load = 1'b1;
                end
            end
            ACCESS:  state_d = ACK;
            FILL:    if (cnt_q == '1) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_start) begin
                data_q <= wdata_i;
                cnt_q  <= '0;
            end
            if (lat_load) begin
                we_q   <= we_i;
                addr_q <= addr_i;
                data_q <= wdata_i;
            end
            // Counter wraps back to 0 naturally on the last fill address.
            if (state_q == FILL) cnt_q <= cnt_q + 1'b1;
            if (state_q == ACCESS && !we_q) rdata_q <= ram_dout_i;
        end
    end

    assign ram_wen_o   = (state_q == FILL) || ((state_q == ACCESS) && we_q);
    assign ram_addr_o  = (state_q == FILL) ? cnt_q : addr_q;
    assign ram_din_o   = data_q;
    assign ack_o       = (state_q == ACK);
    assign busy_o      = (state_q != IDLE);
    assign rdata_o     = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: emulated RAM, a transaction-level model that predicts
// every cycle of output activity, directed scenarios and a random phase.
module tb_ram_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          fill;
    logic          ack_o;
    logic          busy_o;
    logic [DW-1:0] rdata_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_din_o;
    logic [DW-1:0] ram_dout;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .fill_i      (fill),
        .ack_o       (ack_o),
        .busy_o      (busy_o),
        .rdata_o     (rdata_o),
        .ram_wen_o   (ram_wen_o),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_dout_i  (ram_dout),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // emulated RAM: combinational read, write on rising edge
    logic [DW-1:0] ram [DEPTH];
    assign ram_dout = ram[ram_addr_o];
    always @(posedge clk) if (ram_wen_o) ram[ram_addr_o] <= ram_din_o;

    // model: one queue entry per busy cycle, predicting what that cycle shows
    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          ack;
        logic          acc;
        logic          rd;
    } cyc_t;

    cyc_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_rdata;
    logic          was_idle;
    cyc_t          pop_c;
    cyc_t          cur;

    function automatic cyc_t mk(logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                                logic k, logic c, logic r);
        cyc_t e;
        e.wen = w; e.addr = a; e.din = d; e.ack = k; e.acc = c; e.rd = r;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_rdata = '0;
        end else begin
            was_idle = (exp_q.size() == 0);
            if (!was_idle) begin
                pop_c = exp_q.pop_front();
                if (pop_c.wen) model_mem[pop_c.addr] = pop_c.din;
                if (pop_c.rd) exp_rdata = model_mem[pop_c.addr];
            end else if (fill) begin
                for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(1'b1, AW'(i), wdata, 1'b0, 1'b0, 1'b0));
                exp_q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
            end else if (req) begin
                exp_q.push_back(mk(we, addr, wdata, 1'b0, 1'b1, !we));
                exp_q.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, 1'b0));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) cur = exp_q[0];
        else cur = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("busy", {31'd0, busy_o}, {31'd0, exp_q.size() != 0});
        chk("ack", {31'd0, ack_o}, {31'd0, cur.ack});
        chk("ram_wen", {31'd0, ram_wen_o}, {31'd0, cur.wen});
        if (cur.wen || cur.acc) begin
            chk("ram_addr", 32'(ram_addr_o), 32'(cur.addr));
            chk("ram_din", 32'(ram_din_o), 32'(cur.din));
        end
        chk("rdata", 32'(rdata_o), 32'(exp_rdata));
    end

    // driver tasks
    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n >= 200, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        #1 req = 1'b0;
        wait_idle();
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
        do_access(1'b0, a, '0);
        chk(name, 32'(rdata_o), 32'(e));
    endtask

    int wen_cnt;
    int guard;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; fill = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]       = 8'($urandom);
            model_mem[i] = ram[i];
        end
        ram[0] = 8'h11; model_mem[0] = 8'h11;
        #12;
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_wen", {31'd0, ram_wen_o}, 0);
        chk("rst_addr", 32'(ram_addr_o), 0);
        chk("rst_din", 32'(ram_din_o), 0);
        chk("rst_rdata", 32'(rdata_o), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // write then read back, first request right after reset release
        do_access(1'b1, 5'd3, 8'hA5);
        rd_check("rd_a5", 5'd3, 8'hA5);

        // address boundary
        do_access(1'b1, 5'd31, 8'h5A);
        rd_check("rd_31", 5'd31, 8'h5A);
        rd_check("rd_0", 5'd0, 8'h11);

        // fill with 0x00, count write cycles
        wait_idle();
        fill = 1'b1; wdata = 8'h00; wen_cnt = 0;
        @(negedge clk);
        if (ram_wen_o) wen_cnt++;
        #1 fill = 1'b0;
        repeat (39) begin
            @(negedge clk);
            if (ram_wen_o) wen_cnt++;
        end
        chk("fill_wen_cycles", 32'(wen_cnt), 32);
        rd_check("rd_fill0", 5'd17, 8'h00);

        // fill and read in the same cycle; read held until after the fill ack
        wait_idle();
        fill = 1'b1; wdata = 8'h3C; req = 1'b1; we = 1'b0; addr = 5'd7;
        @(negedge clk);
        #1 fill = 1'b0;
        guard = 0;
        while (!ack_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("fill_ack_timeout", guard >= 100, 0);
        @(negedge clk);
        @(negedge clk);
        #1 req = 1'b0;
        wait_idle();
        chk("rd_after_fill", 32'(rdata_o), 32'h3C);

        // req pulsed mid-fill is ignored
        wait_idle();
        fill = 1'b1; wdata = 8'h96;
        @(negedge clk);
        #1 fill = 1'b0;
        repeat (5) @(negedge clk);
        #1 req = 1'b1; we = 1'b1; addr = 5'd2; wdata = 8'hFF;
        @(negedge clk);
        #1 req = 1'b0;
        wait_idle();
        chk("rdata_kept", 32'(rdata_o), 32'h3C);
        rd_check("rd_no_stray_wr", 5'd2, 8'h96);

        // reset while fill counter is 10
        do_access(1'b1, 5'd10, 8'h77);
        wait_idle();
        fill = 1'b1; wdata = 8'hEE;
        @(negedge clk);
        #1 fill = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_o}, 0);
        chk("abort_wen", {31'd0, ram_wen_o}, 0);
        chk("abort_ack", {31'd0, ack_o}, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rd_check("abort_rd9", 5'd9, 8'hEE);
        rd_check("abort_rd10", 5'd10, 8'h77);
        for (int i = 0; i < DEPTH; i++) do_access(1'b0, AW'(i), '0);

        // random phase
        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            if ($urandom_range(0, 19) == 0) begin
                wait_idle();
                fill = 1'b1; wdata = 8'($urandom);
                @(negedge clk);
                #1 fill = 1'b0;
                wait_idle();
            end else begin
                do_access(1'($urandom), AW'($urandom), 8'($urandom));
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
